// File: rtl/fv_core_pkg.sv
// Shared types and decode helpers for the formal core harness.
// Operand-capture fields exist only when FV_EX_SI_CAPTURE_EN is defined.
package fv_core_pkg;
   localparam int FV_NUM_RF_REGS = 32;
   localparam int FV_REG_WIDTH   = 32;
   localparam int FV_ADDR_W      = 32;
   localparam int FV_SIZE_W      = 3;

   localparam logic [6:0] FV_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] FV_OP_JAL    = 7'b1101111;
   localparam logic [6:0] FV_OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic [31:0]          instr;
      logic [FV_SIZE_W-1:0] instr_size;
      logic                 predict_br_taken;
   } fv_if_entry_t;

   typedef struct packed {
      logic [31:0]           instr;
      logic [FV_ADDR_W-1:0]  pc;
      logic [FV_SIZE_W-1:0]  instr_size;
      logic                  expects_kill;
      logic                  received_kill;
      logic                  is_branch;
`ifdef FV_EX_SI_CAPTURE_EN
      logic [FV_REG_WIDTH-1:0] rs1_value;
      logic [FV_REG_WIDTH-1:0] rs2_value;
`endif
   } fv_ex_entry_t;

   function automatic logic fv_instr_is_branch(input logic [31:0] instr);
      return instr[6:0] == FV_OP_BRANCH;
   endfunction

   // Jumps always redirect; a conditional branch only when IF predicted it taken.
   function automatic logic fv_instr_expects_kill(input logic [31:0] instr,
                                                  input logic        predict_br_taken);
      return (instr[6:0] == FV_OP_JAL) || (instr[6:0] == FV_OP_JALR) ||
             (fv_instr_is_branch(instr) && predict_br_taken);
   endfunction

   function automatic logic [4:0] fv_instr_rs1(input logic [31:0] instr);
      return instr[19:15];
   endfunction

   function automatic logic [4:0] fv_instr_rs2(input logic [31:0] instr);
      return instr[24:20];
   endfunction
endpackage

// File: rtl/fv_core_ex_tracker_if.sv
// Bus between the IF/EX harness logic and the execution tracker.
// The arf operand port exists only when FV_EX_SI_CAPTURE_EN is defined.
interface fv_core_ex_tracker_if
   import fv_core_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int IF_W   = 2,
   parameter int CM_W   = 2,
   parameter int ADDR_W = 32,
   parameter int PW     = $clog2(DEPTH) + 1
);
   // Push handshake: a group (|in_valid) is taken on a cycle with enable and no
   // stall/kill when free slots cover popcount(in_valid); otherwise the whole group
   // is dropped and overflow_err latches. push_ready promises room for IF_W lanes.
   logic                     enable;
   fv_if_entry_t [IF_W-1:0]  in_entry;
   logic [IF_W-1:0]          in_valid;
   logic [ADDR_W-1:0]        in_pc;
   logic                     in_stall;
   logic                     in_kill;
   logic                     ex_kill;
   logic                     dut_branch_taken;
   logic [CM_W-1:0]          commit;
   logic [CM_W-1:0]          retire;
`ifdef FV_EX_SI_CAPTURE_EN
   logic [FV_NUM_RF_REGS-1:0][FV_REG_WIDTH-1:0] arf;
`endif
   logic                     push_ready;
   logic                     kill_found;
   fv_ex_entry_t             kill_entry;
   fv_ex_entry_t [CM_W-1:0]  head_entry;
   logic [CM_W-1:0]          head_valid;
   fv_ex_entry_t [CM_W-1:0]  commit_entry;
   logic [CM_W-1:0]          commit_valid;
   logic [PW-1:0]            occupancy;
   logic [PW-1:0]            uncommitted;
   logic                     overflow_err;
   logic                     underflow_err;

   modport master (
      output enable, in_entry, in_valid, in_pc, in_stall, in_kill, ex_kill,
             dut_branch_taken, commit, retire,
`ifdef FV_EX_SI_CAPTURE_EN
             arf,
`endif
      input  push_ready, kill_found, kill_entry, head_entry, head_valid,
             commit_entry, commit_valid, occupancy, uncommitted,
             overflow_err, underflow_err
   );

   modport slave (
      input  enable, in_entry, in_valid, in_pc, in_stall, in_kill, ex_kill,
             dut_branch_taken, commit, retire,
`ifdef FV_EX_SI_CAPTURE_EN
             arf,
`endif
      output push_ready, kill_found, kill_entry, head_entry, head_valid,
             commit_entry, commit_valid, occupancy, uncommitted,
             overflow_err, underflow_err
   );
endinterface

// File: rtl/fv_ex_age_search.sv
// Finds the oldest set bit of a circular mask, age counted from head_idx.
module fv_ex_age_search #(
   parameter int DEPTH = 16,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] mask,
   input  logic [IW-1:0]    head_idx,
   output logic             found,
   output logic [IW-1:0]    idx
);
   logic [IW-1:0] slot;

   // Youngest-to-oldest scan so the oldest hit is the last one to win.
   always_comb begin
      found = 1'b0;
      idx   = head_idx;
      slot  = head_idx;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         slot = head_idx + IW'(k);
         if (mask[slot]) begin
            found = 1'b1;
            idx   = slot;
         end
      end
   end
endmodule

// File: rtl/fv_core_ex_tracker.sv
// In-order execution-tracking queue: records IF->EX instructions, follows commit and
// retire, and locates the oldest kill candidate. Operand capture: FV_EX_SI_CAPTURE_EN.
module fv_core_ex_tracker
   import fv_core_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int IF_W   = 2,
   parameter int CM_W   = 2,
   parameter int ADDR_W = 32,
   parameter int PW     = $clog2(DEPTH) + 1
) (
   input logic                 clk,
   input logic                 reset_,
   fv_core_ex_tracker_if.slave bus
);
   localparam int IW = PW - 1;

   fv_ex_entry_t  mem [DEPTH];
   logic [PW-1:0] head, cptr, tail;
   logic [PW-1:0] occ, unc, done;
   logic          overflow_err, underflow_err;

   assign occ  = tail - head;
   assign unc  = tail - cptr;
   assign done = cptr - head;

   logic [DEPTH-1:0] kill_mask;
   logic [PW-1:0]    slot_age [DEPTH];

   always_comb begin
      kill_mask = '0;
      for (int s = 0; s < DEPTH; s++) begin
         slot_age[s] = {1'b0, IW'(s) - head[IW-1:0]};
         if ((slot_age[s] < occ) && !mem[s].received_kill) begin
            if (bus.dut_branch_taken)
               kill_mask[s] = mem[s].is_branch && (slot_age[s] >= done);
            else
               kill_mask[s] = mem[s].expects_kill;
         end
      end
   end

   logic          kill_found;
   logic [IW-1:0] kill_idx;
   logic [PW-1:0] kill_ptr;

   fv_ex_age_search #(.DEPTH(DEPTH), .IW(IW)) u_age_search (
      .mask     (kill_mask),
      .head_idx (head[IW-1:0]),
      .found    (kill_found),
      .idx      (kill_idx)
   );

   assign kill_ptr = head + {1'b0, kill_idx - head[IW-1:0]};

   logic [PW-1:0]     push_cnt, free_slots;
   logic              push_req, push_ok;
   logic [ADDR_W-1:0] lane_pc  [IF_W];
   logic [PW-1:0]     lane_off [IF_W];
   fv_ex_entry_t      new_ent  [IF_W];

   assign push_cnt   = PW'($countones(bus.in_valid));
   assign free_slots = PW'(DEPTH) - occ;
   assign push_req   = bus.enable && !bus.in_stall && !bus.in_kill && (|bus.in_valid);
   assign push_ok    = push_req && (push_cnt <= free_slots);

   // PCs chain through every lane, valid or not; valid lanes pack densely from tail.
   always_comb begin
      lane_pc[0]  = bus.in_pc;
      lane_off[0] = '0;
      for (int i = 1; i < IF_W; i++) begin
         lane_pc[i]  = lane_pc[i-1] + ADDR_W'(bus.in_entry[i-1].instr_size);
         lane_off[i] = lane_off[i-1] + PW'(bus.in_valid[i-1]);
      end
      for (int i = 0; i < IF_W; i++) begin
         new_ent[i].instr         = bus.in_entry[i].instr;
         new_ent[i].pc            = FV_ADDR_W'(lane_pc[i]);
         new_ent[i].instr_size    = bus.in_entry[i].instr_size;
         new_ent[i].expects_kill  = fv_instr_expects_kill(bus.in_entry[i].instr,
                                                          bus.in_entry[i].predict_br_taken);
         new_ent[i].received_kill = 1'b0;
         new_ent[i].is_branch     = fv_instr_is_branch(bus.in_entry[i].instr);
`ifdef FV_EX_SI_CAPTURE_EN
         new_ent[i].rs1_value     = bus.arf[fv_instr_rs1(bus.in_entry[i].instr)];
         new_ent[i].rs2_value     = bus.arf[fv_instr_rs2(bus.in_entry[i].instr)];
`endif
      end
   end

   logic [PW-1:0] ccnt, rcnt, c_adv, r_adv, tail_n, cptr_n, head_n;
   logic          unf_evt;

   // A truncation can land below cptr (or head) when the killer is already committed.
   always_comb begin
      ccnt    = PW'($countones(bus.commit));
      rcnt    = PW'($countones(bus.retire));
      c_adv   = '0;
      r_adv   = '0;
      unf_evt = 1'b0;
      if (bus.enable) begin
         c_adv   = (ccnt > unc) ? unc : ccnt;
         r_adv   = (rcnt > done) ? done : rcnt;
         unf_evt = (ccnt > unc) || (rcnt > done);
      end
      tail_n = push_ok ? tail + push_cnt : tail;
      if (bus.in_kill && kill_found) tail_n = kill_ptr + PW'(1);
      cptr_n = cptr + c_adv;
      if (PW'(cptr_n - head) > PW'(tail_n - head)) cptr_n = tail_n;
      head_n = head + r_adv;
      if (PW'(head_n - head) > PW'(cptr_n - head)) head_n = cptr_n;
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         head          <= '0;
         cptr          <= '0;
         tail          <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         head <= head_n;
         cptr <= cptr_n;
         tail <= tail_n;
         if (push_req && !push_ok) overflow_err <= 1'b1;
         if (unf_evt) underflow_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_) begin
         if (bus.ex_kill && kill_found)
            mem[kill_idx].received_kill <= mem[kill_idx].is_branch ? bus.dut_branch_taken : 1'b1;
         if (push_ok) begin
            for (int i = 0; i < IF_W; i++) begin
               if (bus.in_valid[i]) mem[IW'(tail + lane_off[i])] <= new_ent[i];
            end
         end
      end
   end

   always_comb begin
      bus.head_entry   = '0;
      bus.head_valid   = '0;
      bus.commit_entry = '0;
      bus.commit_valid = '0;
      for (int k = 0; k < CM_W; k++) begin
         bus.head_entry[k]   = mem[IW'(head + PW'(k))];
         bus.head_valid[k]   = PW'(k) < done;
         bus.commit_entry[k] = mem[IW'(cptr + PW'(k))];
         bus.commit_valid[k] = PW'(k) < unc;
      end
   end

   assign bus.push_ready    = free_slots >= PW'(IF_W);
   assign bus.kill_found    = kill_found;
   assign bus.kill_entry    = mem[kill_idx];
   assign bus.occupancy     = occ;
   assign bus.uncommitted   = unc;
   assign bus.overflow_err  = overflow_err;
   assign bus.underflow_err = underflow_err;
endmodule

// File: tb/tb_fv_core_ex_tracker.sv
// Bench for fv_core_ex_tracker: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the tracked instruction stream.
module tb_fv_core_ex_tracker;
   import fv_core_pkg::*;

   localparam int DEPTH  = 4;
   localparam int IF_W   = 2;
   localparam int CM_W   = 2;
   localparam int ADDR_W = 32;
   localparam int PW     = $clog2(DEPTH) + 1;

   localparam logic [6:0] OP_ALU  = 7'h13;
   localparam logic [6:0] OP_BR   = 7'h63;
   localparam logic [6:0] OP_JAL  = 7'h6F;
   localparam logic [6:0] OP_JALR = 7'h67;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   fv_core_ex_tracker_if #(.DEPTH(DEPTH), .IF_W(IF_W), .CM_W(CM_W), .ADDR_W(ADDR_W)) bus ();

   fv_core_ex_tracker #(.DEPTH(DEPTH), .IF_W(IF_W), .CM_W(CM_W), .ADDR_W(ADDR_W)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

`ifdef FV_EX_SI_CAPTURE_EN
   initial bus.arf = '0;
`endif

   // ---------------- model / scoreboard ----------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  size;
      logic        ek;
      logic        rk;
      logic        br;
   } m_ent_t;

   m_ent_t exp_q[$];
   int     ncom;
   logic   m_ovf, m_unf;
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_ent(input string name, input fv_ex_entry_t a, input m_ent_t e);
      chk({name, ".instr"}, 64'(a.instr), 64'(e.instr));
      chk({name, ".pc"}, 64'(a.pc), 64'(e.pc));
      chk({name, ".flags"}, 64'({a.instr_size, a.expects_kill, a.received_kill, a.is_branch}),
          64'({e.size, e.ek, e.rk, e.br}));
   endtask

   task automatic model_reset();
      exp_q.delete();
      ncom  = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Oldest outstanding entry that can explain a DUT kill this cycle.
   task automatic find_killer(output int j, output bit f);
      f = 1'b0;
      j = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (!f && !exp_q[i].rk &&
             (bus.dut_branch_taken ? (i >= ncom && exp_q[i].br) : exp_q[i].ek)) begin
            f = 1'b1;
            j = i;
         end
      end
   endtask

   task automatic check_outputs();
      int j;
      bit f;
      chk("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
      chk("uncommitted", 64'(bus.uncommitted), 64'(exp_q.size() - ncom));
      chk("push_ready", 64'(bus.push_ready), 64'((DEPTH - exp_q.size()) >= IF_W));
      chk("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
      chk("underflow_err", 64'(bus.underflow_err), 64'(m_unf));
      for (int k = 0; k < CM_W; k++) begin
         chk("head_valid", 64'(bus.head_valid[k]), 64'(k < ncom));
         if (k < ncom) chk_ent("head_entry", bus.head_entry[k], exp_q[k]);
         chk("commit_valid", 64'(bus.commit_valid[k]), 64'(k < exp_q.size() - ncom));
         if (k < exp_q.size() - ncom) chk_ent("commit_entry", bus.commit_entry[k], exp_q[ncom + k]);
      end
      find_killer(j, f);
      chk("kill_found", 64'(bus.kill_found), 64'(f));
      if (f) chk_ent("kill_entry", bus.kill_entry, exp_q[j]);
   endtask

   task automatic model_next();
      int j, nv, ccnt, rcnt, unc, adv_c, adv_r;
      bit f, push;
      logic [31:0] pc;
      m_ent_t e;
      if (!reset_) begin
         model_reset();
         return;
      end
      find_killer(j, f);
      nv   = $countones(bus.in_valid);
      push = bus.enable && !bus.in_stall && !bus.in_kill && (nv > 0);
      if (push && (nv > DEPTH - exp_q.size())) begin
         m_ovf = 1'b1;
         push  = 1'b0;
      end
      if (bus.ex_kill && f) exp_q[j].rk = exp_q[j].br ? bus.dut_branch_taken : 1'b1;
      ccnt  = $countones(bus.commit);
      rcnt  = $countones(bus.retire);
      unc   = exp_q.size() - ncom;
      adv_c = 0;
      adv_r = 0;
      if (bus.enable) begin
         adv_c = (ccnt < unc) ? ccnt : unc;
         adv_r = (rcnt < ncom) ? rcnt : ncom;
         if (ccnt > unc || rcnt > ncom) m_unf = 1'b1;
      end
      if (push) begin
         pc = bus.in_pc;
         for (int i = 0; i < IF_W; i++) begin
            if (bus.in_valid[i]) begin
               e.instr = bus.in_entry[i].instr;
               e.pc    = pc;
               e.size  = bus.in_entry[i].instr_size;
               e.br    = (e.instr[6:0] == OP_BR);
               e.ek    = (e.instr[6:0] == OP_JAL) || (e.instr[6:0] == OP_JALR) ||
                         (e.br && bus.in_entry[i].predict_br_taken);
               e.rk    = 1'b0;
               exp_q.push_back(e);
            end
            pc = pc + 32'(bus.in_entry[i].instr_size);
         end
      end
      if (bus.in_kill && f) begin
         while (exp_q.size() > j + 1) void'(exp_q.pop_back());
      end
      ncom = ncom + adv_c;
      if (ncom > exp_q.size()) ncom = exp_q.size();
      if (adv_r > ncom) adv_r = ncom;
      repeat (adv_r) void'(exp_q.pop_front());
      ncom = ncom - adv_r;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      bus.enable           = 1'b1;
      bus.in_entry         = '0;
      bus.in_valid         = '0;
      bus.in_pc            = '0;
      bus.in_stall         = 1'b0;
      bus.in_kill          = 1'b0;
      bus.ex_kill          = 1'b0;
      bus.dut_branch_taken = 1'b0;
      bus.commit           = '0;
      bus.retire           = '0;
   endtask

   task automatic set_lane(input int i, input logic [6:0] op, input logic [2:0] size, input logic pred);
      logic [31:0] r;
      r = $urandom();
      bus.in_entry[i].instr            = {r[31:7], op};
      bus.in_entry[i].instr_size       = size;
      bus.in_entry[i].predict_br_taken = pred;
   endtask

   task automatic push_group(input logic [1:0] v, input logic [31:0] pc,
                             input logic [6:0] op0, input logic [6:0] op1, input logic [2:0] s0);
      idle();
      set_lane(0, op0, s0, 1'b0);
      set_lane(1, op1, 3'd4, 1'b0);
      bus.in_valid = v;
      bus.in_pc    = pc;
   endtask

   // Inputs are applied at the negedge; outputs checked 1ns later, model advanced with the edge.
   task automatic step();
      #1;
      check_outputs();
      model_next();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic settle();
      idle();
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] ops [4];
      ops = '{OP_ALU, OP_BR, OP_JAL, OP_JALR};

      reset_ = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_ = 1'b1;
      model_reset();
      #1;
      chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
      chk("rst_push_ready", 64'(bus.push_ready), 64'd1);
      chk("rst_kill_found", 64'(bus.kill_found), 64'd0);
      chk("rst_valids", 64'({bus.head_valid, bus.commit_valid}), 64'd0);
      chk("rst_errs", 64'({bus.overflow_err, bus.underflow_err}), 64'd0);

      // fill to DEPTH, then an overflowing push
      push_group(2'b11, 32'h0, OP_ALU, OP_ALU, 3'd4); step();
      push_group(2'b11, 32'h8, OP_ALU, OP_ALU, 3'd4); step();
      settle();
      chk("full_occupancy", 64'(bus.occupancy), 64'd4);
      chk("full_push_ready", 64'(bus.push_ready), 64'd0);
      push_group(2'b01, 32'h10, OP_ALU, OP_ALU, 3'd4); step();
      settle();
      chk("ovf_flag", 64'(bus.overflow_err), 64'd1);
      chk("ovf_occupancy", 64'(bus.occupancy), 64'd4);

      // wrap-around: new entries land in slots 0/1
      idle(); bus.commit = 2'b11; step();
      idle(); bus.retire = 2'b11; step();
      push_group(2'b11, 32'h100, OP_ALU, OP_ALU, 3'd4); step();
      settle();
      chk("wrap_occupancy", 64'(bus.occupancy), 64'd4);
      idle(); bus.commit = 2'b11; step();
      idle(); bus.commit = 2'b11; step();
      idle(); bus.retire = 2'b11; step();
      settle();
      chk("wrap_head0_pc", 64'(bus.head_entry[0].pc), 64'h100);
      chk("wrap_head1_pc", 64'(bus.head_entry[1].pc), 64'h104);
      chk("wrap_occ2", 64'(bus.occupancy), 64'd2);
      idle(); bus.retire = 2'b11; step();

      // non-contiguous lane valid
      push_group(2'b10, 32'h200, OP_ALU, OP_ALU, 3'd2); step();
      settle();
      chk("lane1_occupancy", 64'(bus.occupancy), 64'd1);
      chk("lane1_pc", 64'(bus.commit_entry[0].pc), 64'h202);
      idle(); bus.commit = 2'b01; step();
      idle(); bus.retire = 2'b01; step();

      // taken branch kill with truncation
      push_group(2'b11, 32'h300, OP_ALU, OP_BR, 3'd4); step();
      push_group(2'b01, 32'h308, OP_ALU, OP_ALU, 3'd4); step();
      idle(); bus.dut_branch_taken = 1'b1; bus.ex_kill = 1'b1; bus.in_kill = 1'b1; step();
      idle(); bus.dut_branch_taken = 1'b1; #1;
      chk("kill_trunc_occupancy", 64'(bus.occupancy), 64'd2);
      chk("kill_after_found", 64'(bus.kill_found), 64'd0);
      chk("kill_received", 64'(bus.commit_entry[1].received_kill), 64'd1);

      // commit/retire excess
      idle(); bus.commit = 2'b01; step();
      idle(); bus.commit = 2'b11; step();
      settle();
      chk("unf_uncommitted", 64'(bus.uncommitted), 64'd0);
      chk("unf_flag", 64'(bus.underflow_err), 64'd1);
      idle(); bus.retire = 2'b11; step();
      idle(); bus.retire = 2'b11; step();
      settle();
      chk("retire_excess_occ", 64'(bus.occupancy), 64'd0);

      // mid-operation reset
      push_group(2'b11, 32'h400, OP_ALU, OP_JAL, 3'd4); step();
      push_group(2'b01, 32'h408, OP_ALU, OP_ALU, 3'd4); step();
      settle();
      chk("pre_rst_occupancy", 64'(bus.occupancy), 64'd3);
      reset_ = 1'b0; step();
      reset_ = 1'b1; settle();
      chk("mid_rst_occupancy", 64'(bus.occupancy), 64'd0);
      chk("mid_rst_errs", 64'({bus.overflow_err, bus.underflow_err}), 64'd0);
      chk("mid_rst_push_ready", 64'(bus.push_ready), 64'd1);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         idle();
         reset_               = ($urandom_range(0, 299) != 0);
         bus.enable           = ($urandom_range(0, 9) != 0);
         bus.in_stall         = ($urandom_range(0, 9) == 0);
         bus.in_kill          = ($urandom_range(0, 9) == 0);
         bus.ex_kill          = ($urandom_range(0, 4) == 0);
         bus.dut_branch_taken = ($urandom_range(0, 2) == 0);
         bus.in_valid         = 2'($urandom_range(0, 3));
         bus.in_pc            = $urandom();
         bus.commit           = 2'($urandom_range(0, 3));
         bus.retire           = 2'($urandom_range(0, 3));
         for (int i = 0; i < IF_W; i++)
            set_lane(i, ops[$urandom_range(0, 3)], ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd2,
                     1'($urandom_range(0, 1)));
         step();
      end
      reset_ = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
